booth_seq_multiplier: RTL
=========================

# booth_seq_multiplier

Sequential radix-2 Booth multiplier for signed two's-complement operands. It is the multiply counterpart to the divider in the integer-arithmetic library. It captures two N-bit operands on a start handshake and retires one Booth step per clock. It then delivers a registered 2N-bit product with a one-cycle done pulse. It sits beside the divider as a multi-cycle arithmetic unit, driven by a controller that issues one operation at a time.

## Interface
- N, default 32: operand width in bits; legal range 4 to 64.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- multiplicand  input  N  signed operand M; captured on accept.
- multiplier  input  N  signed operand Q; captured on accept.
- busy  output  1  high while an operation is in flight.
- done  output  1  single-cycle pulse when the product is updated.
- product  output  2N  signed result; holds until the next completion.
- overflow  output  1  present only with MULT_OVF_EN; see Configuration.

## Operation
- States: IDLE and RUN.
- IDLE with start=1: accept the request and go to RUN. Load the following on the same edge:
  - A = 0, an (N+1)-bit accumulator.
  - Mx = multiplicand sign-extended to N+1 bits.
  - Qr = multiplier.
  - q_1 = 0.
  - cnt = N.
- IDLE with start=0: stay in IDLE.
- RUN, one step per edge, selected by {Qr[0], q_1}:
  - 01: A = A + Mx.
  - 10: A = A - Mx.
  - 00 or 11: A unchanged.
  - Then arithmetic-shift {A, Qr, q_1} right by one, replicating A[N].
  - Then cnt = cnt - 1.
- The accumulator is N+1 bits so that A - Mx cannot overflow when M = -2^(N-1).
- Final step (cnt == 1):
  - product <= {A[N-1:0], Qr} using the post-shift values.
  - done <= 1.
  - busy <= 0.
  - State returns to IDLE.
- start during RUN is ignored and not queued.
- Operand inputs may change freely after the accept edge.
- done is high for exactly one cycle; product is stable from that edge onward.

## Timing
- Reset values: state=IDLE, busy=0, done=0, product=0, overflow=0, internal registers 0.
- Reset mid-operation aborts the operation. product returns to 0 and no done pulse is issued.
- Accept at edge k: busy=1 after edge k.
- done=1 and product valid after edge k+N. busy=0 after the same edge.
- Latency is N cycles from the accept edge to the done edge.
- The earliest next accept is edge k+N+1, so the initiation interval is N+1 cycles.
- start held high continuously gives back-to-back operations, one every N+1 cycles.
- start high while done=1 is accepted, because the state is already IDLE.
- Latency is data-independent; there is no early termination.

## Configuration
- MULT_OVF_EN defined:
  - The overflow output exists.
  - It is registered together with product, on the same edge.
  - overflow = 1 when the product is not representable in N signed bits, i.e. product[2N-1:N-1] is not all-equal.
  - Otherwise overflow = 0.
  - It holds until the next completion and resets to 0.
- MULT_OVF_EN undefined: the overflow port and its logic are absent. All other behaviour is identical.

## Test plan
- N=32, M=3, Q=5, pulse start:
  - done exactly 32 cycles after accept.
  - product = 0x0000_0000_0000_000F.
  - overflow = 0.
- M=-7, Q=6: product = 0xFFFF_FFFF_FFFF_FFD6 (-42), overflow = 0.
- M=0x8000_0000, Q=0x8000_0000: product = 0x4000_0000_0000_0000, overflow = 1.
- M=0x7FFF_FFFF, Q=-1:
  - product = 0xFFFF_FFFF_8000_0001, overflow = 0.
  - During RUN, also pulse start with other operands: they are ignored and busy does not restart.
- Start M=12, Q=12, then assert reset at cycle 10 of RUN:
  - busy, done and product go to 0 immediately.
  - No done pulse follows.
  - A new start with M=2, Q=-3 gives product = 0xFFFF_FFFF_FFFF_FFFA.
- Hold start high with operands (1,1) then (-1,-1):
  - done pulses 33 cycles apart.
  - Products are 1 and 1.
  - product holds between the pulses.

Source files
------------

// File: rtl/booth_seq_multiplier.sv
// Sequential radix-2 Booth multiplier: N-bit signed operands, one Booth step per clock, 2N-bit product.
// Optional MULT_OVF_EN adds a registered overflow flag (product not representable in N signed bits).
module booth_seq_multiplier #(
  parameter int N = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [N-1:0]     multiplicand,
  input  logic [N-1:0]     multiplier,
  output logic             busy,
  output logic             done,
  output logic [2*N-1:0]   product
`ifdef MULT_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [N:0]       r_acc;
  logic [N:0]       r_mx;
  logic [N-1:0]     r_qr;
  logic             r_q1;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [2*N-1:0]   r_product;

  logic [N:0]       w_sum;
  logic [N:0]       w_acc_sh;
  logic [N-1:0]     w_qr_sh;
  logic             w_q1_sh;
  logic [2*N-1:0]   w_prod;

  // The extra accumulator bit keeps A - Mx exact when M is the most negative value.
  always_comb begin
    // NOTE: default assignment first so no path leaves w_sum unassigned (no latch).
    w_sum = r_acc;
    case ({r_qr[0], r_q1})
      2'b01:   w_sum = r_acc + r_mx;
      2'b10:   w_sum = r_acc - r_mx;
      default: w_sum = r_acc;
    endcase
  end

  assign w_acc_sh = {w_sum[N], w_sum[N:1]};
  assign w_qr_sh  = {w_sum[0], r_qr[N-1:1]};
  assign w_q1_sh  = r_qr[0];
  assign w_prod   = {w_acc_sh[N-1:0], w_qr_sh};

`ifdef MULT_OVF_EN
  logic w_ovf;
  logic r_overflow;
  assign w_ovf    = ~((&w_prod[2*N-1:N-1]) | ~(|w_prod[2*N-1:N-1]));
  assign overflow = r_overflow;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_acc     <= '0;
      r_mx      <= '0;
      r_qr      <= '0;
      r_q1      <= 1'b0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
`ifdef MULT_OVF_EN
      r_overflow <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc   <= '0;
            r_mx    <= {multiplicand[N-1], multiplicand};
            r_qr    <= multiplier;
            r_q1    <= 1'b0;
            r_cnt   <= CW'(N);
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc <= w_acc_sh;
          r_qr  <= w_qr_sh;
          r_q1  <= w_q1_sh;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_product <= w_prod;
`ifdef MULT_OVF_EN
            r_overflow <= w_ovf;
`endif
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;

endmodule
